// File: rtl/ps2_keycode_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ps2_keycode_rx
// Brief   : PS/2 keyboard receiver translating make/break scan codes into a
//           held-key HID usage code. Define PS2_PARITY_CHECK_EN to discard
//           frames whose odd parity is wrong.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_keycode_rx #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_press,
    output logic       frame_err
);

    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    logic             clk_s1_q, clk_s1_d;
    logic             clk_s2_q, clk_s2_d;
    logic             clk_s3_q, clk_s3_d;
    logic             dat_s1_q, dat_s1_d;
    logic             dat_s2_q, dat_s2_d;
    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [8:0]       shift_q, shift_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic             byte_vld_q, byte_vld_d;
    logic             ext_q, ext_d;
    logic             brk_q, brk_d;
    logic [7:0]       keycode_q, keycode_d;
    logic             key_press_q, key_press_d;
    logic             frame_err_q, frame_err_d;

    logic             w_fall;
    logic             w_bit;
    logic             w_timeout;
    logic [7:0]       w_mapped;

    function automatic logic [7:0] map_code(input logic [8:0] key);
        logic [7:0] code;
        case (key)
            9'h01D:  code = 8'h1A;
            9'h01C:  code = 8'h04;
            9'h01B:  code = 8'h16;
            9'h023:  code = 8'h07;
            9'h033:  code = 8'h0B;
            9'h076:  code = 8'h29;
            9'h029:  code = 8'h2C;
            9'h05A:  code = 8'h28;
            9'h175:  code = 8'h52;
            9'h172:  code = 8'h51;
            9'h16B:  code = 8'h50;
            9'h174:  code = 8'h4F;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    assign w_fall    = clk_s3_q & ~clk_s2_q;
    assign w_bit     = dat_s2_q;
    assign w_timeout = (state_q != ST_IDLE) && !w_fall && (tmo_cnt_q >= TMO_LAST);
    assign w_mapped  = map_code({ext_q, byte_q});

    always_comb begin
        clk_s1_d    = ps2_clk;
        clk_s2_d    = clk_s1_q;
        clk_s3_d    = clk_s2_q;
        dat_s1_d    = ps2_data;
        dat_s2_d    = dat_s1_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tmo_cnt_d   = tmo_cnt_q;
        byte_d      = byte_q;
        byte_vld_d  = 1'b0;
        ext_d       = ext_q;
        brk_d       = brk_q;
        keycode_d   = keycode_q;
        key_press_d = 1'b0;
        frame_err_d = 1'b0;

        // Saturating inactivity counter, only meaningful while inside a frame
        if (state_q == ST_IDLE || w_fall) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_MAX) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        if (w_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_bit) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        shift_d   = '0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {w_bit, shift_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    shift_d = {w_bit, shift_q[8:1]};
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                    if (!w_bit) begin
                        frame_err_d = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        // shift_q holds 8 data bits plus parity; XOR of 0 means even
                        if (!(^shift_q)) begin
                            frame_err_d = 1'b1;
                            ext_d       = 1'b0;
                            brk_d       = 1'b0;
                        end else begin
                            byte_vld_d = 1'b1;
                            byte_d     = shift_q[7:0];
                        end
`else
                        byte_vld_d = 1'b1;
                        byte_d     = shift_q[7:0];
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (w_timeout) begin
            state_d     = ST_IDLE;
            bit_cnt_d   = 3'd0;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end

        // Second stage: prefix tracking and held-key update for an accepted byte
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                if (!brk_q) begin
                    if (w_mapped != 8'h00) begin
                        keycode_d   = w_mapped;
                        key_press_d = (w_mapped != keycode_q);
                    end
                end else if (w_mapped == keycode_q) begin
                    keycode_d = 8'h00;
                end
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_s3_q    <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            tmo_cnt_q   <= '0;
            byte_q      <= 8'h00;
            byte_vld_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            keycode_q   <= 8'h00;
            key_press_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_s3_q    <= clk_s3_d;
            dat_s1_q    <= dat_s1_d;
            dat_s2_q    <= dat_s2_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tmo_cnt_q   <= tmo_cnt_d;
            byte_q      <= byte_d;
            byte_vld_q  <= byte_vld_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            keycode_q   <= keycode_d;
            key_press_q <= key_press_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign keycode   = keycode_q;
    assign key_press = key_press_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ps2_keycode_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ps2_keycode_rx
// Brief   : Self-checking bench for ps2_keycode_rx against a scan-code model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_keycode_rx;

    localparam int TMO  = 200;
    localparam int HALF = 15;
`ifdef PS2_PARITY_CHECK_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] keycode;
    logic       key_press;
    logic       frame_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] map_tbl [logic [8:0]];
    logic [7:0] m_kc;
    bit         m_ext;
    bit         m_brk;
    logic [9:0] exp_tr [1:5];
    logic [9:0] obs_tr [1:5];

    ps2_keycode_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .Clk      (clk),
        .Reset_n  (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keycode  (keycode),
        .key_press(key_press),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] lookup(input bit ext, input logic [7:0] b);
        logic [8:0] k;
        k = {ext, b};
        return map_tbl.exists(k) ? map_tbl[k] : 8'h00;
    endfunction

    task automatic model_reset();
        m_kc = 8'h00; m_ext = 1'b0; m_brk = 1'b0;
    endtask

    // Expected {keycode,key_press,frame_err} after posedges 1..5 following the stop-bit fall
    task automatic model_frame(input logic [7:0] b, input logic p, input bit stop);
        logic [7:0] old_kc, code;
        bit err, press;
        old_kc = m_kc; err = 1'b0; press = 1'b0;
        if (!stop) begin
            err = 1'b1;
        end else if (PARITY_EN && (^{b, p}) == 1'b0) begin
            err = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            code = lookup(m_ext, b);
            if (!m_brk) begin
                if (code != 8'h00) begin
                    press = (code != m_kc);
                    m_kc  = code;
                end
            end else if (code == m_kc) begin
                m_kc = 8'h00;
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
        exp_tr[1] = {old_kc, 2'b00};
        exp_tr[2] = {old_kc, 2'b00};
        exp_tr[3] = {old_kc, 1'b0, err};
        exp_tr[4] = {m_kc, press, 1'b0};
        exp_tr[5] = {m_kc, 2'b00};
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        wait_clk(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop);
        logic p;
        p = par_ok ? ~^b : ^b;
        model_frame(b, p, stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(p);
        ps2_data = stop;
        wait_clk(HALF);
        ps2_clk = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            obs_tr[i] = {keycode, key_press, frame_err};
        end
        wait_clk(HALF);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        model_reset();
        wait_clk(2);
        checks++;
        if (keycode !== 8'h00) begin errors++; $display("FAIL reset_keycode: got %h, required 00", keycode); end
        checks++;
        if (key_press !== 1'b0) begin errors++; $display("FAIL reset_key_press: got %b, required 0", key_press); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b, required 0", frame_err); end
    endtask

    task automatic test_make();
        send_frame(8'h1D, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_tr[i] !== exp_tr[i]) begin errors++;
                $display("FAIL make_1d cyc%0d kc/kp/fe: got %h, required %h", i, obs_tr[i], exp_tr[i]); end
        end
        checks++;
        if (keycode !== 8'h1A) begin errors++; $display("FAIL make_1d_final: got %h, required 1a", keycode); end
    endtask

    task automatic test_extended();
        logic [7:0] seq [5] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        for (int f = 0; f < 5; f++) begin
            send_frame(seq[f], 1'b1, 1'b1);
            for (int i = 1; i <= 5; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin errors++;
                    $display("FAIL ext_seq f%0d cyc%0d kc/kp/fe: got %h, required %h", f, i, obs_tr[i], exp_tr[i]); end
            end
            if (f == 1) begin
                checks++;
                if (keycode !== 8'h52) begin errors++; $display("FAIL ext_up_arrow: got %h, required 52", keycode); end
            end
        end
        checks++;
        if (keycode !== 8'h00) begin errors++; $display("FAIL ext_release: got %h, required 00", keycode); end
    endtask

    task automatic test_typematic();
        logic [7:0] seq [4] = '{8'h1D, 8'hF0, 8'h1C, 8'h1D};
        for (int f = 0; f < 4; f++) begin
            send_frame(seq[f], 1'b1, 1'b1);
            for (int i = 1; i <= 5; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin errors++;
                    $display("FAIL typematic f%0d cyc%0d kc/kp/fe: got %h, required %h", f, i, obs_tr[i], exp_tr[i]); end
            end
        end
        checks++;
        if (keycode !== 8'h1A) begin errors++; $display("FAIL typematic_hold: got %h, required 1a", keycode); end
    endtask

    task automatic test_parity();
        send_frame(8'h76, 1'b0, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_tr[i] !== exp_tr[i]) begin errors++;
                $display("FAIL bad_parity cyc%0d kc/kp/fe: got %h, required %h", i, obs_tr[i], exp_tr[i]); end
        end
        checks++;
        if (keycode !== (PARITY_EN ? 8'h1A : 8'h29)) begin errors++;
            $display("FAIL bad_parity_final: got %h, required %h", keycode, PARITY_EN ? 8'h1A : 8'h29); end
    endtask

    task automatic test_stop_error();
        int fe_cnt;
        send_frame(8'h5A, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_tr[i] !== exp_tr[i]) begin errors++;
                $display("FAIL bad_stop cyc%0d kc/kp/fe: got %h, required %h", i, obs_tr[i], exp_tr[i]); end
        end
        // A lone clock pulse with data high in IDLE must not start a frame
        ps2_bit(1'b1);
        fe_cnt = 0;
        for (int i = 0; i < TMO + 40; i++) begin
            @(posedge clk); #1;
            if (frame_err) fe_cnt++;
        end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL idle_high_start: got %0d frame_err pulses, required 0", fe_cnt); end
    endtask

    task automatic test_timeout();
        int   fe_cnt;
        logic [7:0] kc_before;
        send_frame(8'hE0, 1'b1, 1'b1);
        kc_before = m_kc;
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'(i[0]));
        m_ext = 1'b0; m_brk = 1'b0;
        fe_cnt = 0;
        for (int i = 0; i < TMO + 60; i++) begin
            @(posedge clk); #1;
            if (frame_err) fe_cnt++;
        end
        checks++;
        if (fe_cnt !== 1) begin errors++; $display("FAIL timeout_pulse: got %0d frame_err pulses, required 1", fe_cnt); end
        checks++;
        if (keycode !== kc_before) begin errors++; $display("FAIL timeout_keycode: got %h, required %h", keycode, kc_before); end
        send_frame(8'h33, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_tr[i] !== exp_tr[i]) begin errors++;
                $display("FAIL after_timeout cyc%0d kc/kp/fe: got %h, required %h", i, obs_tr[i], exp_tr[i]); end
        end
        checks++;
        if (keycode !== 8'h0B) begin errors++; $display("FAIL after_timeout_final: got %h, required 0b", keycode); end
    endtask

    task automatic test_reset_midframe();
        int fe_cnt;
        send_frame(8'h23, 1'b1, 1'b1);
        checks++;
        if (keycode !== 8'h07) begin errors++; $display("FAIL pre_reset_keycode: got %h, required 07", keycode); end
        send_frame(8'hE0, 1'b1, 1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        model_reset();
        fe_cnt = 0;
        for (int i = 0; i < TMO + 40; i++) begin
            @(posedge clk); #1;
            if (frame_err) fe_cnt++;
        end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL reset_midframe_err: got %0d frame_err pulses, required 0", fe_cnt); end
        checks++;
        if (keycode !== 8'h00) begin errors++; $display("FAIL reset_midframe_keycode: got %h, required 00", keycode); end
        send_frame(8'h1D, 1'b1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (obs_tr[i] !== exp_tr[i]) begin errors++;
                $display("FAIL after_reset cyc%0d kc/kp/fe: got %h, required %h", i, obs_tr[i], exp_tr[i]); end
        end
    endtask

    task automatic test_random();
        logic [7:0] plain [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h33, 8'h76, 8'h29, 8'h5A};
        logic [7:0] extc  [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
        logic [7:0] b;
        int         r;
        bit         stop, par_ok;
        for (int f = 0; f < 40; f++) begin
            r = int'($urandom_range(0, 15));
            if (r < 8)        b = plain[r];
            else if (r == 8)  b = 8'hE0;
            else if (r == 9)  b = 8'hF0;
            else if (r < 12)  b = extc[$urandom_range(0, 3)];
            else              b = 8'($urandom_range(0, 255));
            stop   = ($urandom_range(0, 7) != 0);
            par_ok = ($urandom_range(0, 7) != 0);
            send_frame(b, par_ok, stop);
            for (int i = 1; i <= 5; i++) begin
                checks++;
                if (obs_tr[i] !== exp_tr[i]) begin errors++;
                    $display("FAIL random f%0d byte=%h stop=%0d par_ok=%0d cyc%0d kc/kp/fe: got %h, required %h",
                             f, b, stop, par_ok, i, obs_tr[i], exp_tr[i]); end
            end
        end
    endtask

    initial begin
        map_tbl[9'h01D] = 8'h1A; map_tbl[9'h01C] = 8'h04; map_tbl[9'h01B] = 8'h16;
        map_tbl[9'h023] = 8'h07; map_tbl[9'h033] = 8'h0B; map_tbl[9'h076] = 8'h29;
        map_tbl[9'h029] = 8'h2C; map_tbl[9'h05A] = 8'h28;
        map_tbl[9'h175] = 8'h52; map_tbl[9'h172] = 8'h51;
        map_tbl[9'h16B] = 8'h50; map_tbl[9'h174] = 8'h4F;
        model_reset();

        test_reset();
        test_make();
        test_extended();
        test_typematic();
        test_parity();
        test_stop_error();
        test_timeout();
        test_reset_midframe();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, idle Clk cycles mid-frame before abort (1 ms at 50 MHz).
REQ-002 SHALL have port Clk  input  1  system clock (MAX10_CLK1_50 domain).
REQ-003 SHALL have port Reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port ps2_clk  input  1  PS/2 device clock, asynchronous to Clk.
REQ-005 SHALL have port ps2_data  input  1  PS/2 device data, asynchronous to Clk.
REQ-006 SHALL have port keycode  output  8  HID usage code of the currently held mapped key, 8'h00 when none.
REQ-007 SHALL have port key_press  output  1  one-cycle pulse when keycode changes to a nonzero value.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers; a falling edge is synchronized previous=1 and current=0.
REQ-010 SHALL run FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, advancing only on falling edges.
REQ-011 IDLE: data=0 at the edge -> DATA with bit count 0; data=1 -> remain IDLE, no error.
REQ-012 DATA: shift 8 bits LSB first; after bit 7 -> PARITY.
REQ-013 PARITY: capture parity bit -> STOP.
REQ-014 STOP: data=1 -> byte accepted; data=0 -> frame_err pulse, byte discarded; either way -> IDLE.
REQ-015 In any state other than IDLE, TIMEOUT_CYCLES Clk cycles without a falling edge -> IDLE, bit count cleared, frame_err pulse, prefix flags cleared.
REQ-016 Byte 8'hE0 SHALL set ext flag; 8'hF0 SHALL set brk flag; neither changes keycode.
REQ-017 Any other accepted byte SHALL be translated using {ext, byte}, then both flags cleared.
REQ-018 Mapping (non-ext): 1D->1A, 1C->04, 1B->16, 23->07, 33->0B, 76->29, 29->2C, 5A->28; (ext): 75->52, 72->51, 6B->50, 74->4F; all else -> 00.
REQ-019 Make (brk=0) of a mapped key: keycode <= mapped code; key_press pulses only if the new value differs from the old keycode (typematic repeat gives no pulse).
REQ-020 Make of an unmapped key SHALL leave keycode unchanged.
REQ-021 Break (brk=1) SHALL clear keycode to 00 only if the mapped code equals the current keycode; otherwise no change.
REQ-022 keycode and key_press SHALL update exactly 2 Clk cycles after the synchronized falling edge that samples a valid stop bit.
REQ-023 frame_err SHALL pulse 1 Clk cycle after the causing edge or timeout; it SHALL NOT coincide with key_press.
REQ-024 Timeout counter SHALL saturate, never wrap, and reset on every falling edge.

Reset
REQ-025 With Reset_n=0 at a Clk edge: state=IDLE, bit count=0, shift reg=0, ext=brk=0, timeout count=0, keycode=8'h00, key_press=0, frame_err=0, synchronizer flops=1.
REQ-026 Reset mid-frame SHALL abandon the frame with no frame_err; the next frame SHALL be received normally.

Configuration
REQ-027 Macro PS2_PARITY_CHECK_EN: when defined, an accepted byte whose 8 data bits plus parity bit have even parity SHALL be discarded with a frame_err pulse and flags cleared.
REQ-028 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be sampled and ignored; only the stop bit and timeout generate frame_err.

Verification
REQ-029 Frame 8'h1D, odd parity, stop=1 -> keycode=8'h1A 2 cycles after stop edge, key_press one pulse.
REQ-030 Frames E0,75 then E0,F0,75 -> keycode 8'h52 with pulse, then 8'h00, no pulse on release.
REQ-031 Keycode 8'h1A held; frames F0,1C -> keycode stays 8'h1A; repeat 1D -> no key_press.
REQ-032 Frame 8'h76 with bad parity -> with macro: frame_err pulse, keycode unchanged; without: keycode=8'h29.
REQ-033 Start plus 3 data bits then ps2_clk held high for TIMEOUT_CYCLES -> frame_err pulse, then frame 8'h33 -> keycode=8'h0B.
REQ-034 Reset_n=0 for 1 cycle mid-frame with keycode=8'h07 -> keycode=8'h00, no frame_err, next valid frame decoded correctly.
